// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the display VRAM read sequencer.
// Holds the sequencer state enum, default frame geometry and burst sizing helpers.
package disp_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        HALT       = 2'd0,
        WAIT_FRAME = 2'd1,
        ADDR       = 2'd2,
        DATA       = 2'd3
    } disp_state_t;

    // Default frame geometry (32 bit per pixel)
    localparam int H_PIXELS_DEF = 640;
    localparam int V_LINES_DEF  = 480;

    // Bytes moved by one burst of 32-bit beats
    function automatic int burst_bytes(input int burst_len);
        return burst_len * 4;
    endfunction

    // Number of bursts needed to fetch one whole frame
    function automatic int total_bursts(input int h_pixels, input int v_lines, input int burst_len);
        return (h_pixels * v_lines) / burst_len;
    endfunction

endpackage

// File: rtl/disp_vsync_det.sv
// disp_vsync_det: two-flop synchronizer plus falling-edge pulse for an
// asynchronous active-low sync input. Also usable for VBLANK detection.
module disp_vsync_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic fall_pulse
);

    logic sync_a;
    logic sync_b;
    logic sync_prev;

    // Synchronize the input, keep one cycle of history and emit a registered one-cycle pulse on a 1->0 transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a     <= 1'b1;
            sync_b     <= 1'b1;
            sync_prev  <= 1'b1;
            fall_pulse <= 1'b0;
        end else begin
            sync_a     <= async_in;
            sync_b     <= sync_a;
            sync_prev  <= sync_b;
            fall_pulse <= sync_prev & ~sync_b;
        end
    end

endmodule

// File: rtl/disp_vramctrl.sv
// disp_vramctrl: once-per-frame VRAM fetch sequencer feeding the display line buffer.
// Issues fixed-length AXI read bursts, one outstanding at a time, throttled by buffer space.
// Optional macro DISP_VRAMCTRL_RRESP_EN adds RRESP input and sticky VRAM_ERR output.
module disp_vramctrl
    import disp_pkg::*;
#(
    parameter int H_PIXELS  = H_PIXELS_DEF,
    parameter int V_LINES   = V_LINES_DEF,
    parameter int BURST_LEN = 16
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        DSP_VSYNC_X,
    input  logic        DISPON,
    input  logic [28:0] DISPADDR,
    input  logic        BUF_WREADY,
    output logic        BUF_WR,
    output logic [31:0] BUF_WDATA,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
`ifdef DISP_VRAMCTRL_RRESP_EN
    input  logic [1:0]  RRESP,
    output logic        VRAM_ERR,
`endif
    output logic        FRAME_BUSY
);

    localparam int BURST_BYTES  = burst_bytes(BURST_LEN);
    localparam int TOTAL_BURSTS = total_bursts(H_PIXELS, V_LINES, BURST_LEN);
    localparam int CNT_W        = (TOTAL_BURSTS > 1) ? $clog2(TOTAL_BURSTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(TOTAL_BURSTS - 1);

    // Reject geometries that do not split into whole bursts or illegal burst lengths
    if (((H_PIXELS * V_LINES) % BURST_LEN) != 0) begin : g_bad_geometry
        $error("disp_vramctrl: H_PIXELS*V_LINES must be a multiple of BURST_LEN");
    end
    if ((BURST_LEN < 1) || (BURST_LEN > 256) || ((BURST_LEN & (BURST_LEN - 1)) != 0)) begin : g_bad_burst
        $error("disp_vramctrl: BURST_LEN must be a power of two no larger than 256");
    end

    disp_state_t       state;
    disp_state_t       state_n;
    logic [28:0]       base;
    logic [28:0]       base_n;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              arvalid_n;
    logic [31:0]       araddr_n;
    logic              rready_n;
    logic              wr_n;
    logic [31:0]       wdata_n;
    logic              busy_n;
    logic              vs_start;
    logic              beat;
    logic [31:0]       burst_addr;
    logic              unused_addr_bits;

    // The low address bits are dropped by the 64-byte base alignment
    assign unused_addr_bits = ^DISPADDR[5:0];

    assign ARLEN      = 8'(BURST_LEN - 1);
    assign beat       = RVALID & RREADY;
    assign burst_addr = {3'b000, base} + (32'(burst_cnt) * 32'(BURST_BYTES));

    disp_vsync_det u_vsync_det (
        .clk        (ACLK),
        .rst_n      (ARST),
        .async_in   (DSP_VSYNC_X),
        .fall_pulse (vs_start)
    );

    // Next-state and next-output decode; every register holds its value unless a state says otherwise
    always_comb begin
        state_n   = state;
        base_n    = base;
        cnt_n     = burst_cnt;
        arvalid_n = ARVALID;
        araddr_n  = ARADDR;
        rready_n  = RREADY;
        wr_n      = 1'b0;
        wdata_n   = BUF_WDATA;
        busy_n    = FRAME_BUSY;
        case (state)
            HALT: begin
                arvalid_n = 1'b0;
                rready_n  = 1'b0;
                busy_n    = 1'b0;
                if (DISPON) begin
                    state_n = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (!DISPON) begin
                    state_n = HALT;
                end else if (vs_start) begin
                    base_n  = {DISPADDR[28:6], 6'b0};
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = ADDR;
                end
            end
            ADDR: begin
                if (ARVALID) begin
                    if (ARREADY) begin
                        arvalid_n = 1'b0;
                        rready_n  = 1'b1;
                        state_n   = DATA;
                    end
                end else if (!DISPON) begin
                    busy_n  = 1'b0;
                    state_n = HALT;
                end else if (BUF_WREADY) begin
                    arvalid_n = 1'b1;
                    araddr_n  = burst_addr;
                end
            end
            DATA: begin
                if (beat) begin
                    wr_n    = 1'b1;
                    wdata_n = RDATA;
                    if (RLAST) begin
                        rready_n = 1'b0;
                        if (burst_cnt == LAST_BURST) begin
                            busy_n  = 1'b0;
                            state_n = DISPON ? WAIT_FRAME : HALT;
                        end else begin
                            cnt_n = burst_cnt + 1'b1;
                            if (DISPON) begin
                                state_n = ADDR;
                            end else begin
                                busy_n  = 1'b0;
                                state_n = HALT;
                            end
                        end
                    end
                end
            end
            default: begin
                state_n = HALT;
            end
        endcase
    end

    // State and registered outputs; reset abandons any burst in flight
    always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
            state      <= HALT;
            base       <= '0;
            burst_cnt  <= '0;
            ARVALID    <= 1'b0;
            ARADDR     <= '0;
            RREADY     <= 1'b0;
            BUF_WR     <= 1'b0;
            BUF_WDATA  <= '0;
            FRAME_BUSY <= 1'b0;
        end else begin
            state      <= state_n;
            base       <= base_n;
            burst_cnt  <= cnt_n;
            ARVALID    <= arvalid_n;
            ARADDR     <= araddr_n;
            RREADY     <= rready_n;
            BUF_WR     <= wr_n;
            BUF_WDATA  <= wdata_n;
            FRAME_BUSY <= busy_n;
        end
    end

`ifdef DISP_VRAMCTRL_RRESP_EN
    // Sticky error flag: any error beat sets it, frame start clears it, set wins
    always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
            VRAM_ERR <= 1'b0;
        end else if (beat && (RRESP != 2'b00)) begin
            VRAM_ERR <= 1'b1;
        end else if (vs_start) begin
            VRAM_ERR <= 1'b0;
        end
    end
`endif

endmodule
